// File: rtl/lvds_pkg.sv
// lvds_pkg: shared state type and constants for the LVDS receive aligner
package lvds_pkg;
  localparam int WORD_W = 8;
  localparam logic [WORD_W-1:0] SYNC_DEFAULT = 8'hBC;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} align_state_t;
endpackage

// File: rtl/lvds_sync_detect.sv
// lvds_sync_detect: lowest bit rotation of {prev, cur} that holds the sync byte
module lvds_sync_detect import lvds_pkg::*; #(
  parameter logic [WORD_W-1:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic [2*WORD_W-1:0] c,
  output logic                hit,
  output logic [2:0]          offset
);
  logic [7:0] match;
  for (genvar k = 0; k < 8; k++) begin : g_win
    assign match[k] = c[k +: WORD_W] == SYNC_BYTE;
  end
  always_comb begin
    hit = |match;
    offset = '0;
    for (int i = 7; i >= 0; i--) if (match[i]) offset = 3'(i);
  end
endmodule

// File: rtl/lvds_rx_aligner.sv
// lvds_rx_aligner: LVDS word aligner and frame synchroniser; define ALIGN_ERR_CNT_EN to add the err_cnt sync-error counter
module lvds_rx_aligner import lvds_pkg::*; #(
  parameter logic [WORD_W-1:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int FRAME_LEN = 16,
  parameter int VERIFY_N = 3,
  parameter int MISS_N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] rx_data,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              sof,
  output logic              locked,
  output logic [2:0]        bit_offset
`ifdef ALIGN_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);
  localparam int GW = $clog2(VERIFY_N + 1);
  localparam int MW = $clog2(MISS_N + 1);
  localparam logic [7:0] SYNC_POS = 8'(FRAME_LEN);
  align_state_t state;
  logic [WORD_W-1:0] prev, aligned_r;
  logic [2*WORD_W-1:0] c;
  logic [7:0] pos;
  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;
  logic [2:0] hit_offset;
  logic arm, hit, sync_slot, sync_ok, payload;
  assign c = {prev, rx_data};
  assign locked = state == LOCKED;
  assign sync_slot = state != HUNT && !arm && pos == SYNC_POS;
  assign sync_ok = aligned_r == SYNC_BYTE;
  assign payload = locked && pos != SYNC_POS;
  lvds_sync_detect #(.SYNC_BYTE(SYNC_BYTE)) u_detect (.c(c), .hit(hit), .offset(hit_offset));
  // arm holds pos for the one cycle aligned_r still carries the sync word found in HUNT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HUNT;
      prev <= '0;
      aligned_r <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      sof <= 1'b0;
      bit_offset <= '0;
      pos <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
      arm <= 1'b0;
    end else begin
      prev <= rx_data;
      aligned_r <= c[bit_offset +: WORD_W];
      arm <= 1'b0;
      data_valid <= payload;
      sof <= locked && pos == 8'd0;
      data_out <= payload ? aligned_r : data_out;
      if (state != HUNT && !arm) pos <= pos == SYNC_POS ? 8'd0 : pos + 8'd1;
      if (state == HUNT && hit) begin
        state <= VERIFY;
        bit_offset <= hit_offset;
        pos <= 8'd0;
        good_cnt <= '0;
        arm <= 1'b1;
      end
      if (sync_slot && state == VERIFY) begin
        if (!sync_ok) state <= HUNT;
        else begin
          good_cnt <= good_cnt + GW'(1);
          if (good_cnt == GW'(VERIFY_N - 1)) begin
            state <= LOCKED;
            miss_cnt <= '0;
          end
        end
      end
      if (sync_slot && state == LOCKED) begin
        if (sync_ok) miss_cnt <= '0;
        else begin
          miss_cnt <= miss_cnt + MW'(1);
          if (miss_cnt == MW'(MISS_N - 1)) state <= HUNT;
        end
      end
    end
  end
`ifdef ALIGN_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt <= '0;
    else if (sync_slot && !sync_ok && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif
endmodule
